// File: rtl/spi_lbus_pkg.sv
// Shared definitions for the SPI-to-local-bus slave: instruction layout,
// length decoding constant and the frame state encoding.
package spi_lbus_pkg;

    // Instruction word = R/W bit + length field + address field.
    function automatic int instr_w(input int addr_w, input int len_w);
        return 1 + len_w + addr_w;
    endfunction

    // Bit index of the R/W flag inside the instruction word.
    function automatic int rw_pos(input int addr_w, input int len_w);
        return addr_w + len_w;
    endfunction

    // All-ones length code selects unbounded streaming; slice to LEN_W.
    localparam logic [31:0] LEN_STREAM = '1;

    typedef enum logic [1:0] {
        INSTR = 2'd0,
        DATA  = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_lbus_addr_step.sv
// Word address pointer for multi-word transfers.
// Ports: sclk/reset_spi; load_i + load_val_i seed the pointer, step_i
// advances it by one (down when STEP_DOWN != 0) modulo 2^ADDR_W;
// issue_o is the address used by the strobe issued on this edge.
import spi_lbus_pkg::*;

module spi_lbus_addr_step #(
    parameter int ADDR_W    = 13,
    parameter int STEP_DOWN = 1
) (
    input  logic              sclk,
    input  logic              reset_spi,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] issue_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // A load on the same edge as a step bypasses the stored pointer so the
    // first read word can be issued and stepped in one cycle.
    assign issue_o = load_i ? load_val_i : ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (step_i) begin
            if (STEP_DOWN != 0) ptr_d = issue_o - 1'b1;
            else                ptr_d = issue_o + 1'b1;
        end else if (load_i) begin
            ptr_d = load_val_i;
        end
    end

    always_ff @(posedge sclk or posedge reset_spi) begin
        if (reset_spi) ptr_q <= '0;
        else           ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spi_slave_lbus_mb.sv
// SPI (mode 0) slave bridging to a register-file local bus, with
// instruction phase (R/W, length, address) and multi-word transfers.
// Ports: sclk, reset_spi (async high, frame delimiter), mosi, miso,
// dir (1 = master drives pad), rdata, rd_en, wr_en, wdata, address.
import spi_lbus_pkg::*;

module spi_slave_lbus_mb #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 2,
    parameter int STEP_DOWN = 1
) (
    input  logic              sclk,
    input  logic              reset_spi,
    input  logic              mosi,
    output logic              miso,
    output logic              dir,
    input  logic [DATA_W-1:0] rdata,
    output logic              rd_en,
    output logic              wr_en,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] address
);

    localparam int INSTR_W = instr_w(ADDR_W, LEN_W);
    localparam int RW_POS  = rw_pos(ADDR_W, LEN_W);
    localparam int MAX_W   = (INSTR_W > DATA_W) ? INSTR_W : DATA_W;
    localparam int CNT_W   = $clog2(MAX_W);

    localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(INSTR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [LEN_W-1:0] LEN_ALL1   = LEN_STREAM[LEN_W-1:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INSTR_W-2:0] ins_q, ins_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              rw_q, rw_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              miso_q, miso_d;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] tx_q, tx_d;

    logic [INSTR_W-1:0] instr_full;
    logic              stream;
    logic              last_word;
    logic              ptr_load;
    logic              ptr_step;
    logic [ADDR_W-1:0] ptr_issue;

    assign instr_full = {ins_q, mosi};
    assign stream     = (len_q == LEN_ALL1);
    assign last_word  = !stream && (wcnt_q == len_q);

    spi_lbus_addr_step #(
        .ADDR_W    (ADDR_W),
        .STEP_DOWN (STEP_DOWN)
    ) u_addr_step (
        .sclk       (sclk),
        .reset_spi  (reset_spi),
        .load_i     (ptr_load),
        .load_val_i (instr_full[ADDR_W-1:0]),
        .step_i     (ptr_step),
        .issue_o    (ptr_issue)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        ins_d    = instr_full[INSTR_W-2:0];
        rx_d     = {rx_q[DATA_W-2:0], mosi};
        rw_d     = rw_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        ptr_load = 1'b0;
        ptr_step = 1'b0;
        unique case (state_q)
            INSTR: begin
                if (cnt_q == INSTR_LAST) begin
                    cnt_d    = '0;
                    state_d  = DATA;
                    rw_d     = instr_full[RW_POS];
                    len_d    = instr_full[ADDR_W +: LEN_W];
                    wcnt_d   = '0;
                    ptr_load = 1'b1;
                    // Reads fetch word 1 now so it is ready for shifting.
                    if (instr_full[RW_POS]) begin
                        ptr_step = 1'b1;
                        rd_en_d  = 1'b1;
                        addr_d   = ptr_issue;
                    end
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (!stream) wcnt_d = wcnt_q + 1'b1;
                    if (last_word) state_d = DONE;
                    if (rw_q) begin
                        // Prefetch the next word only if one follows.
                        if (!last_word) begin
                            ptr_step = 1'b1;
                            rd_en_d  = 1'b1;
                            addr_d   = ptr_issue;
                        end
                    end else begin
                        ptr_step = 1'b1;
                        wr_en_d  = 1'b1;
                        wdata_d  = rx_d;
                        addr_d   = ptr_issue;
                    end
                end
            end
            DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = INSTR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge reset_spi) begin
        if (reset_spi) begin
            state_q <= INSTR;
            cnt_q   <= '0;
            ins_q   <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            len_q   <= '0;
            wcnt_q  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ins_q   <= ins_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
        end
    end

    // Falling-edge side: the negedge right after a read strobe captures
    // rdata and presents its MSB; later negedges shift the rest out.
    always_comb begin
        miso_d = 1'b0;
        dir_d  = 1'b1;
        tx_d   = tx_q;
        if (state_q == DATA && rw_q) begin
            dir_d = 1'b0;
            if (rd_en_q) begin
                miso_d = rdata[DATA_W-1];
                tx_d   = {rdata[DATA_W-2:0], 1'b0};
            end else begin
                miso_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(negedge sclk or posedge reset_spi) begin
        if (reset_spi) begin
            miso_q <= 1'b0;
            dir_q  <= 1'b1;
            tx_q   <= '0;
        end else begin
            miso_q <= miso_d;
            dir_q  <= dir_d;
            tx_q   <= tx_d;
        end
    end

    assign miso    = miso_q;
    assign dir     = dir_q;
    assign rd_en   = rd_en_q;
    assign wr_en   = wr_en_q;
    assign wdata   = wdata_q;
    assign address = addr_q;

endmodule

// File: tb/tb_spi_slave_lbus_mb.sv
// Scoreboard bench for spi_slave_lbus_mb: three instances (default,
// incrementing pointer, 16-bit data / 5-bit address) share sclk and mosi.
module tb_spi_slave_lbus_mb;

    typedef struct {
        bit          rd;
        logic [12:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   sel = 0;

    logic        a_miso, a_dir, a_rd, a_wr;
    logic [7:0]  a_wdata, a_rdata;
    logic [12:0] a_addr;
    logic        b_miso, b_dir, b_rd, b_wr;
    logic [7:0]  b_wdata, b_rdata;
    logic [12:0] b_addr;
    logic        c_miso, c_dir, c_rd, c_wr;
    logic [15:0] c_wdata, c_rdata;
    logic [4:0]  c_addr;

    logic [7:0]  mem8 [8192];
    logic [15:0] mem16 [32];

    assign a_rdata = mem8[a_addr];
    assign b_rdata = mem8[b_addr];
    assign c_rdata = mem16[c_addr];

    spi_slave_lbus_mb dut_a (
        .sclk(sclk), .reset_spi(rst_a), .mosi(mosi), .miso(a_miso),
        .dir(a_dir), .rdata(a_rdata), .rd_en(a_rd), .wr_en(a_wr),
        .wdata(a_wdata), .address(a_addr)
    );

    spi_slave_lbus_mb #(.STEP_DOWN(0)) dut_b (
        .sclk(sclk), .reset_spi(rst_b), .mosi(mosi), .miso(b_miso),
        .dir(b_dir), .rdata(b_rdata), .rd_en(b_rd), .wr_en(b_wr),
        .wdata(b_wdata), .address(b_addr)
    );

    spi_slave_lbus_mb #(.ADDR_W(5), .DATA_W(16), .LEN_W(2)) dut_c (
        .sclk(sclk), .reset_spi(rst_c), .mosi(mosi), .miso(c_miso),
        .dir(c_dir), .rdata(c_rdata), .rd_en(c_rd), .wr_en(c_wr),
        .wdata(c_wdata), .address(c_addr)
    );

    always #5 sclk = ~sclk;

    logic        m_rst, m_miso, m_dir, m_rd, m_wr;
    logic [12:0] m_addr;
    logic [15:0] m_wdata;

    always_comb begin
        m_rst = rst_a; m_miso = a_miso; m_dir = a_dir;
        m_rd = a_rd; m_wr = a_wr; m_addr = a_addr;
        m_wdata = {8'h0, a_wdata};
        if (sel == 1) begin
            m_rst = rst_b; m_miso = b_miso; m_dir = b_dir;
            m_rd = b_rd; m_wr = b_wr; m_addr = b_addr;
            m_wdata = {8'h0, b_wdata};
        end else if (sel == 2) begin
            m_rst = rst_c; m_miso = c_miso; m_dir = c_dir;
            m_rd = c_rd; m_wr = c_wr; m_addr = {8'h0, c_addr};
            m_wdata = c_wdata;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int pc = 0;
    exp_t        exp_q [$];
    logic [15:0] rxw_q [$];

    always @(posedge sclk) pc <= m_rst ? 0 : pc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Strobe monitor: local-bus outputs are stable at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge sclk);
            if (m_rd || m_wr) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL strobe_extra: rd=%0b wr=%0b addr=%0h cyc=%0d want none",
                             m_rd, m_wr, m_addr, pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_rd", 32'(m_rd), 32'(e.rd));
                    chk("strobe_wr", 32'(m_wr), 32'(!e.rd));
                    chk("strobe_addr", 32'(m_addr), 32'(e.addr));
                    chk("strobe_cyc", pc, e.cyc);
                    if (!e.rd) chk("wdata", 32'(m_wdata), 32'(e.data));
                end
            end
        end
    end

    // Master-side receiver: sample miso just after each rising edge
    // while the slave owns the pad.
    initial begin
        logic [15:0] sh;
        logic [15:0] got;
        int nb;
        sh = '0;
        nb = 0;
        forever begin
            @(posedge sclk);
            #1;
            if (m_rst) begin
                nb = 0;
            end else if (!m_dir) begin
                sh = {sh[14:0], m_miso};
                nb++;
                if (nb == ((sel == 2) ? 16 : 8)) begin
                    nb = 0;
                    got = (sel == 2) ? sh : {8'h0, sh[7:0]};
                    if (rxw_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL miso_extra: got %0h want none", got);
                    end else begin
                        chk("miso_word", 32'(got), 32'(rxw_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic start(input int s);
        @(negedge sclk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; mosi = 1'b0;
        @(negedge sclk);
        sel = s;
        @(negedge sclk);
        if (s == 0) rst_a = 1'b0;
        else if (s == 1) rst_b = 1'b0;
        else rst_c = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            @(posedge sclk);
            @(negedge sclk);
        end
    endtask

    task automatic abort();
        #2;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    endtask

    task automatic push(input bit rd, input logic [12:0] a,
                        input logic [15:0] d, input int cyc);
        exp_t e;
        e.rd = rd; e.addr = a; e.data = d; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drained(input string name);
        chk({name, "_strobes_left"}, exp_q.size(), 0);
        chk({name, "_words_left"}, rxw_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem8[i] = 8'h00;
        for (int i = 0; i < 32; i++) mem16[i] = 16'h0000;
        mem8[13'h100] = 8'h3C;
        mem8[13'h0FF] = 8'hC3;
        mem8[13'h1FFF] = 8'h5A;
        mem8[13'h0000] = 8'h96;
        mem8[13'h0001] = 8'h69;
        mem16[5] = 16'hBEEF;
        mem16[4] = 16'h1234;
        mem16[3] = 16'h8001;

        repeat (3) @(negedge sclk);
        chk("rst_miso", 32'(a_miso), 0);
        chk("rst_dir", 32'(a_dir), 1);
        chk("rst_rd_en", 32'(a_rd), 0);
        chk("rst_wr_en", 32'(a_wr), 0);
        chk("rst_wdata", 32'(a_wdata), 0);
        chk("rst_address", 32'(a_addr), 0);

        // Single write, then extra clocks that must be ignored.
        start(0);
        push(1'b0, 13'h055, 16'h00A5, 24);
        send_bits(48'h0055, 16);
        send_bits(48'hA5, 8);
        send_bits(48'hFFFF, 16);
        #1;
        chk("w1_dir", 32'(a_dir), 1);
        chk("w1_addr_hold", 32'(a_addr), 32'h055);
        drained("w1");

        // Two-word read, decrementing address.
        start(0);
        push(1'b1, 13'h100, 16'h0, 16);
        push(1'b1, 13'h0FF, 16'h0, 24);
        rxw_q.push_back(16'h003C);
        rxw_q.push_back(16'h00C3);
        send_bits(48'hA100, 16);
        #1;
        chk("r2_dir_n16", 32'(a_dir), 0);
        send_bits(48'h0, 8);
        #1;
        chk("r2_dir_n24", 32'(a_dir), 0);
        send_bits(48'h0, 8);
        #1;
        chk("r2_dir_n32", 32'(a_dir), 1);
        chk("r2_miso_done", 32'(a_miso), 0);
        send_bits(48'h0, 8);
        drained("r2");

        // Streaming write from 0 wraps to the top of the space.
        start(0);
        push(1'b0, 13'h0000, 16'h11, 24);
        push(1'b0, 13'h1FFF, 16'h22, 32);
        push(1'b0, 13'h1FFE, 16'h33, 40);
        push(1'b0, 13'h1FFD, 16'h44, 48);
        send_bits(48'h6000, 16);
        send_bits(48'h11223344, 32);
        abort();
        repeat (2) @(negedge sclk);
        drained("sw");

        // Streaming read, incrementing from the top address wraps to 0.
        start(1);
        push(1'b1, 13'h1FFF, 16'h0, 16);
        push(1'b1, 13'h0000, 16'h0, 24);
        push(1'b1, 13'h0001, 16'h0, 32);
        rxw_q.push_back(16'h005A);
        rxw_q.push_back(16'h0096);
        send_bits(48'hFFFF, 16);
        send_bits(48'h0, 16);
        abort();
        repeat (2) @(negedge sclk);
        drained("sr");

        // Reset part way into a write word: no strobe.
        start(0);
        send_bits(48'h0033, 16);
        send_bits(48'hF, 4);
        abort();
        repeat (4) @(negedge sclk);
        drained("ab");
        start(0);
        push(1'b0, 13'h002, 16'h7E, 24);
        send_bits(48'h0002, 16);
        send_bits(48'h7E, 8);
        send_bits(48'h0, 8);
        drained("ab2");

        // 16-bit data, 5-bit address, three-word read.
        start(2);
        push(1'b1, 13'h05, 16'h0, 8);
        push(1'b1, 13'h04, 16'h0, 24);
        push(1'b1, 13'h03, 16'h0, 40);
        rxw_q.push_back(16'hBEEF);
        rxw_q.push_back(16'h1234);
        rxw_q.push_back(16'h8001);
        send_bits(48'hC5, 8);
        send_bits(48'h0, 48);
        #1;
        chk("w16_dir_done", 32'(c_dir), 1);
        send_bits(48'hFFFF, 16);
        chk("w16_addr_hold", 32'(c_addr), 32'h03);
        drained("w16");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
